// File: rtl/spi_reg_controller.sv
// spi_reg_controller: bridges a byte-oriented SPI subordinate to a simple
// register bus with auto-incrementing address bursts.
//
// First byte of a transaction is the command: MSB=1 read, MSB=0 write,
// low bits are the start address. Write bursts then stream data bytes to
// consecutive registers; read bursts prefetch the next register every time
// the SPI side loads a transmit byte. Write bursts echo the error flags in
// the first transmitted data byte.
//
// Ports:
//   clk, reset_n            system clock, async active-low reset
//   chip_select_n           raw SPI chip select (async, active-low)
//   spi_wr_req/spi_rx_data  received byte strobe and data
//   spi_rd_req/spi_tx_data  transmit-load strobe and registered tx byte
//   reg_addr/reg_wdata      register bus address and write data
//   reg_we/reg_re           write/read strobes, held until reg_ack
//   reg_rdata/reg_ack       read data and one-cycle completion
//   busy, err_*             status; error flags sticky per transaction
//
// state | meaning
// IDLE  | no transaction, waiting for chip select to assert
// CMD   | waiting for the command byte
// WDATA | write burst, waiting for the next data byte
// WACC  | register write in flight (reg_we held)
// RACC  | register read in flight (reg_re held)
// RHOLD | read data parked in spi_tx_data, waiting for the SPI to take it
module spi_reg_controller #(
    parameter int SPI_BUS_WIDTH = 8,
    parameter int ACK_TIMEOUT   = 15
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     chip_select_n,
    input  logic                     spi_wr_req,
    input  logic                     spi_rd_req,
    input  logic [SPI_BUS_WIDTH-1:0] spi_rx_data,
    output logic [SPI_BUS_WIDTH-1:0] spi_tx_data,
    output logic [SPI_BUS_WIDTH-2:0] reg_addr,
    output logic [SPI_BUS_WIDTH-1:0] reg_wdata,
    output logic                     reg_we,
    output logic                     reg_re,
    input  logic [SPI_BUS_WIDTH-1:0] reg_rdata,
    input  logic                     reg_ack,
    output logic                     busy,
    output logic                     err_overrun,
    output logic                     err_underrun,
    output logic                     err_timeout
);

    localparam int AW = SPI_BUS_WIDTH - 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    // Loaded when a strobe rises; the strobe is dropped on the edge that
    // finds the counter at zero, giving exactly ACK_TIMEOUT cycles high.
    localparam logic [TW-1:0] TMR_LOAD = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, CMD, WDATA, WACC, RACC, RHOLD} state_t;

    state_t                   state, state_n;
    logic [1:0]               cs_sync;
    logic                     cs_prev;
    logic                     cs_active, cs_rise;
    logic [AW-1:0]            addr, addr_n;
    logic [SPI_BUS_WIDTH-1:0] tx, tx_n, wdata, wdata_n;
    logic                     we_q, we_n, re_q, re_n;
    logic                     ov, ov_n, un, un_n, to, to_n;
    logic [TW-1:0]            tmr, tmr_n;

    assign cs_active = ~cs_sync[1];
    assign cs_rise   = cs_active & ~cs_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync <= 2'b11;
            cs_prev <= 1'b0;
            state   <= IDLE;
            addr    <= '0;
            tx      <= '0;
            wdata   <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            ov      <= 1'b0;
            un      <= 1'b0;
            to      <= 1'b0;
            tmr     <= '0;
        end else begin
            cs_sync <= {cs_sync[0], chip_select_n};
            cs_prev <= cs_active;
            state   <= state_n;
            addr    <= addr_n;
            tx      <= tx_n;
            wdata   <= wdata_n;
            we_q    <= we_n;
            re_q    <= re_n;
            ov      <= ov_n;
            un      <= un_n;
            to      <= to_n;
            tmr     <= tmr_n;
        end
    end

    always_comb begin
        state_n = state;
        addr_n  = addr;
        tx_n    = tx;
        wdata_n = wdata;
        we_n    = we_q;
        re_n    = re_q;
        ov_n    = ov;
        un_n    = un;
        to_n    = to;
        tmr_n   = tmr;
        if (state != IDLE && !cs_active) begin
            // Abort: whatever access was in flight is abandoned, address kept.
            state_n = IDLE;
            we_n    = 1'b0;
            re_n    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_rise) begin
                        state_n = CMD;
                        tx_n    = '0;
                        ov_n    = 1'b0;
                        un_n    = 1'b0;
                        to_n    = 1'b0;
                    end
                end
                CMD: begin
                    if (spi_wr_req) begin
                        addr_n = spi_rx_data[AW-1:0];
                        if (spi_rx_data[SPI_BUS_WIDTH-1]) begin
                            state_n = RACC;
                            re_n    = 1'b1;
                            tmr_n   = TMR_LOAD;
                        end else begin
                            state_n   = WDATA;
                            tx_n      = '0;
                            tx_n[2:0] = {to, un, ov};
                        end
                    end
                end
                WDATA: begin
                    if (spi_wr_req) begin
                        state_n = WACC;
                        wdata_n = spi_rx_data;
                        we_n    = 1'b1;
                        tmr_n   = TMR_LOAD;
                    end
                end
                WACC: begin
                    if (spi_wr_req) ov_n = 1'b1;
                    if (reg_ack || tmr == '0) begin
                        state_n = WDATA;
                        we_n    = 1'b0;
                        addr_n  = addr + AW'(1);
                        if (!reg_ack) to_n = 1'b1;
                    end else begin
                        tmr_n = tmr - TW'(1);
                    end
                end
                RACC: begin
                    if (spi_rd_req) un_n = 1'b1;
                    if (reg_ack) begin
                        state_n = RHOLD;
                        re_n    = 1'b0;
                        tx_n    = reg_rdata;
                    end else if (tmr == '0) begin
                        state_n = RHOLD;
                        re_n    = 1'b0;
                        tx_n    = '1;
                        to_n    = 1'b1;
                    end else begin
                        tmr_n = tmr - TW'(1);
                    end
                end
                RHOLD: begin
                    if (spi_rd_req) begin
                        state_n = RACC;
                        addr_n  = addr + AW'(1);
                        re_n    = 1'b1;
                        tmr_n   = TMR_LOAD;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Gating with cs_active drops a strobe as soon as the abort is seen,
    // one cycle before the state register returns to IDLE.
    assign reg_we       = we_q & cs_active;
    assign reg_re       = re_q & cs_active;
    assign reg_addr     = addr;
    assign reg_wdata    = wdata;
    assign spi_tx_data  = tx;
    assign busy         = (state != IDLE);
    assign err_overrun  = ov;
    assign err_underrun = un;
    assign err_timeout  = to;

endmodule

// File: tb/tb_spi_reg_controller.sv
module tb_spi_reg_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       chip_select_n;
    logic       spi_wr_req;
    logic       spi_rd_req;
    logic [7:0] spi_rx_data;
    logic [7:0] spi_tx_data;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       reg_ack;
    logic       busy, err_overrun, err_underrun, err_timeout;

    spi_reg_controller #(.SPI_BUS_WIDTH(8), .ACK_TIMEOUT(15)) dut (
        .clk(clk), .reset_n(reset_n), .chip_select_n(chip_select_n),
        .spi_wr_req(spi_wr_req), .spi_rd_req(spi_rd_req),
        .spi_rx_data(spi_rx_data), .spi_tx_data(spi_tx_data),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .reg_ack(reg_ack),
        .busy(busy), .err_overrun(err_overrun),
        .err_underrun(err_underrun), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         wr;
        logic [6:0] addr;
        logic [7:0] data;
    } acc_t;
    acc_t exp_q[$];

    // register-bus responder controls
    bit   resp_en  = 1'b0;
    int   ack_lat  = 2;
    logic resp_ack = 1'b0;
    logic man_ack  = 1'b0;
    assign reg_ack = resp_ack | man_ack;

    bit         no_access = 1'b0;
    bit         prev_strobe = 1'b0;
    logic [6:0] prev_addr = '0;
    int         re_len = 0;
    int         last_re_len = 0;
    int         cs_high_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Register slave: acks a held strobe after ack_lat cycles, rdata = addr + 0x10.
    initial begin
        int lat_cnt;
        lat_cnt   = 0;
        reg_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            resp_ack = 1'b0;
            if (resp_en && reset_n && (reg_we || reg_re)) begin
                if (lat_cnt == ack_lat) begin
                    resp_ack  = 1'b1;
                    reg_rdata = {1'b0, reg_addr} + 8'h10;
                    lat_cnt   = 0;
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Compare process: bus rules and completed accesses against the expected list.
    always @(negedge clk) begin
        acc_t a;
        if (!reset_n) begin
            prev_strobe = 1'b0;
            re_len      = 0;
            cs_high_cnt = 0;
        end else begin
            chk("we_re_exclusive", {31'b0, reg_we & reg_re}, 0);
            if (prev_strobe && (reg_we || reg_re))
                chk("addr_stable", {25'b0, reg_addr}, {25'b0, prev_addr});
            if (no_access)
                chk("no_access", {31'b0, reg_we | reg_re}, 0);
            if (cs_high_cnt >= 4) begin
                chk("idle_busy", {31'b0, busy}, 0);
                chk("idle_strobe", {31'b0, reg_we | reg_re}, 0);
            end
            if (reg_ack && (reg_we || reg_re)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_access actual we=%0b addr=%0h required none", reg_we, reg_addr);
                end else begin
                    a = exp_q.pop_front();
                    chk("acc_kind", {31'b0, reg_we}, {31'b0, a.wr});
                    chk("acc_addr", {25'b0, reg_addr}, {25'b0, a.addr});
                    if (a.wr) chk("acc_wdata", {24'b0, reg_wdata}, {24'b0, a.data});
                end
            end
            if (reg_re) re_len++;
            else if (re_len != 0) begin
                last_re_len = re_len;
                re_len      = 0;
            end
            prev_strobe = reg_we || reg_re;
            prev_addr   = reg_addr;
            cs_high_cnt = chip_select_n ? cs_high_cnt + 1 : 0;
        end
    end

    task automatic push_acc(input bit wr, input logic [6:0] a, input logic [7:0] d);
        acc_t e;
        e.wr = wr; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic spi_byte(input logic [7:0] b);
        @(posedge clk); #1;
        spi_wr_req  = 1'b1;
        spi_rx_data = b;
        @(posedge clk); #1;
        spi_wr_req  = 1'b0;
    endtask

    task automatic rd_pulse();
        @(posedge clk); #1;
        spi_rd_req = 1'b1;
        @(posedge clk); #1;
        spi_rd_req = 1'b0;
    endtask

    task automatic cs_on();
        @(posedge clk); #1;
        chip_select_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic cs_off();
        @(posedge clk); #1;
        chip_select_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe_done(input string name, input int maxc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < maxc && !done; i++) begin
            @(negedge clk);
            if (!(reg_we || reg_re)) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s strobe still high after %0d cycles, required low", name, maxc);
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        reset_n = 1'b0; chip_select_n = 1'b1;
        spi_wr_req = 1'b0; spi_rd_req = 1'b0; spi_rx_data = '0;
        #23;
        chk("rst_tx", {24'b0, spi_tx_data}, 0);
        chk("rst_addr", {25'b0, reg_addr}, 0);
        chk("rst_wdata", {24'b0, reg_wdata}, 0);
        chk("rst_strobes_busy", {29'b0, reg_we, reg_re, busy}, 0);
        chk("rst_errs", {29'b0, err_timeout, err_underrun, err_overrun}, 0);
        @(negedge clk); reset_n = 1'b1;
        repeat (3) @(posedge clk);

        // write burst 0x05, 0xAA, 0xBB
        resp_en = 1'b1; ack_lat = 2;
        push_acc(1, 7'h05, 8'hAA);
        push_acc(1, 7'h06, 8'hBB);
        cs_on();
        chk("wr_busy", {31'b0, busy}, 1);
        spi_byte(8'h05);
        chk("wr_status_byte", {24'b0, spi_tx_data}, 0);
        spi_byte(8'hAA);
        chk("wr_we_up", {31'b0, reg_we}, 1);
        wait_strobe_done("wr_aa", 30);
        spi_byte(8'hBB);
        wait_strobe_done("wr_bb", 30);
        chk("wr_addr_next", {25'b0, reg_addr}, 7'h07);
        chk("wr_errs", {29'b0, err_timeout, err_underrun, err_overrun}, 0);
        cs_off();
        chk("wr_queue", exp_q.size(), 0);

        // read burst with address wrap
        push_acc(0, 7'h7F, 0);
        push_acc(0, 7'h00, 0);
        push_acc(0, 7'h01, 0);
        cs_on();
        spi_byte(8'hFF);
        wait_strobe_done("rd_7f", 30);
        chk("rd_tx_8f", {24'b0, spi_tx_data}, 8'h8F);
        rd_pulse();
        wait_strobe_done("rd_00", 30);
        chk("rd_tx_10", {24'b0, spi_tx_data}, 8'h10);
        rd_pulse();
        wait_strobe_done("rd_01", 30);
        chk("rd_tx_11", {24'b0, spi_tx_data}, 8'h11);
        chk("rd_errs", {29'b0, err_timeout, err_underrun, err_overrun}, 0);
        cs_off();
        chk("rd_queue", exp_q.size(), 0);

        // read timeout
        resp_en = 1'b0;
        cs_on();
        spi_byte(8'h83);
        wait_strobe_done("to_wait", 40);
        chk("to_re_len", last_re_len, 15);
        chk("to_flag", {31'b0, err_timeout}, 1);
        chk("to_tx", {24'b0, spi_tx_data}, 8'hFF);
        chk("to_addr", {25'b0, reg_addr}, 7'h03);
        chk("to_busy", {31'b0, busy}, 1);
        cs_off();

        // overrun during a write
        resp_en = 1'b1; ack_lat = 4;
        cs_on();
        chk("new_cs_to_clr", {31'b0, err_timeout}, 0);
        chk("new_cs_tx_clr", {24'b0, spi_tx_data}, 0);
        push_acc(1, 7'h10, 8'h55);
        spi_byte(8'h10);
        spi_byte(8'h55);
        spi_byte(8'h66);
        wait_strobe_done("ov_wait", 30);
        chk("ov_flag", {31'b0, err_overrun}, 1);
        chk("ov_addr", {25'b0, reg_addr}, 7'h11);
        repeat (5) @(posedge clk);
        cs_off();
        chk("ov_queue", exp_q.size(), 0);

        // underrun during a read
        cs_on();
        chk("new_cs_ov_clr", {31'b0, err_overrun}, 0);
        push_acc(0, 7'h10, 0);
        spi_byte(8'h90);
        rd_pulse();
        wait_strobe_done("un_wait", 30);
        chk("un_flag", {31'b0, err_underrun}, 1);
        chk("un_tx", {24'b0, spi_tx_data}, 8'h20);
        cs_off();
        cs_on();
        chk("new_cs_un_clr", {31'b0, err_underrun}, 0);
        cs_off();

        // abort with a write pending, then a late ack
        resp_en = 1'b0;
        cs_on();
        spi_byte(8'h20);
        spi_byte(8'h77);
        repeat (2) @(posedge clk);
        #1;
        chip_select_n = 1'b1;
        n = 0;
        for (int i = 0; i < 6 && reg_we; i++) begin
            @(negedge clk);
            n++;
        end
        chk("abort_we_low", {31'b0, reg_we}, 0);
        if (n > 3) chk("abort_latency", n, 3);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_busy", {31'b0, busy}, 0);
        man_ack = 1'b1;
        @(posedge clk); #1;
        man_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("late_ack_addr", {25'b0, reg_addr}, 7'h20);
        chk("late_ack_state", {28'b0, busy, err_timeout, err_underrun, err_overrun}, 0);
        chk("late_ack_strobes", {30'b0, reg_we, reg_re}, 0);

        // reset while parked in RHOLD
        resp_en = 1'b1; ack_lat = 1;
        push_acc(0, 7'h05, 0);
        cs_on();
        spi_byte(8'h85);
        wait_strobe_done("rh_read", 30);
        chk("rh_tx", {24'b0, spi_tx_data}, 8'h15);
        @(posedge clk); #3;
        reset_n = 1'b0;
        chip_select_n = 1'b1;
        #1;
        chk("rh_rst_tx", {24'b0, spi_tx_data}, 0);
        chk("rh_rst_addr", {25'b0, reg_addr}, 0);
        chk("rh_rst_ctl", {27'b0, busy, reg_we, reg_re, err_timeout, err_overrun}, 0);
        no_access = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("rh_idle_busy", {31'b0, busy}, 0);
        no_access = 1'b0;
        push_acc(1, 7'h01, 8'h3C);
        cs_on();
        spi_byte(8'h01);
        spi_byte(8'h3C);
        wait_strobe_done("rh_write", 30);
        cs_off();
        chk("final_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/spi_reg_controller.md
SPI_REG_CONTROLLER -- requirements
Module: spi_reg_controller

Interface
REQ-001 SHALL have parameter SPI_BUS_WIDTH, default 8: SPI byte width; register address width is SPI_BUS_WIDTH-1.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 15: maximum clk cycles a register strobe waits for reg_ack.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port chip_select_n  input  1  raw SPI chip select, active-low, asynchronous to clk.
REQ-006 SHALL have port spi_wr_req  input  1  one-cycle pulse: SPI subordinate has completed receiving a byte.
REQ-007 SHALL have port spi_rd_req  input  1  one-cycle pulse: SPI subordinate is loading spi_tx_data for the next byte in this cycle.
REQ-008 SHALL have port spi_rx_data  input  SPI_BUS_WIDTH  received byte, valid while spi_wr_req is high.
REQ-009 SHALL have port spi_tx_data  output  SPI_BUS_WIDTH  byte to transmit, registered, stable between updates.
REQ-010 SHALL have port reg_addr  output  SPI_BUS_WIDTH-1  register address.
REQ-011 SHALL have port reg_wdata  output  SPI_BUS_WIDTH  register write data.
REQ-012 SHALL have port reg_we / reg_re  output  1 each  write/read strobes, level-held until acknowledged.
REQ-013 SHALL have port reg_rdata  input  SPI_BUS_WIDTH  read data, valid while reg_ack is high.
REQ-014 SHALL have port reg_ack  input  1  one-cycle access completion.
REQ-015 SHALL have ports busy, err_overrun, err_underrun, err_timeout  output  1 each  status.

Function
REQ-016 SHALL pass chip_select_n through a 2-stage synchronizer; cs_active = synchronized low; all transaction logic uses cs_active.
REQ-017 SHALL implement states IDLE, CMD, WDATA, WACC, RACC, RHOLD; busy = (state != IDLE).
REQ-018 IDLE -> CMD on cs_active rising; at this transition, clear all three error flags and set spi_tx_data to 0.
REQ-019 CMD, spi_wr_req: latch addr = spi_rx_data[SPI_BUS_WIDTH-2:0]; if spi_rx_data MSB = 1, go to RACC; otherwise load spi_tx_data = {0..., err_timeout, err_underrun, err_overrun} and go to WDATA.
REQ-020 WDATA, spi_wr_req: reg_wdata = spi_rx_data, assert reg_we on the next cycle, go to WACC.
REQ-021 WACC: when reg_ack is sampled high, drop reg_we the following cycle, increment addr, return to WDATA.
REQ-022 RACC: assert reg_re. When reg_ack is sampled high, load spi_tx_data = reg_rdata, drop reg_re, go to RHOLD.
REQ-023 RHOLD, spi_rd_req: increment addr, go to RACC (prefetch of the next byte). Ignore spi_wr_req (dummy bytes) in RHOLD, RACC.
REQ-024 Address SHALL wrap from 2^(SPI_BUS_WIDTH-1)-1 to 0.
REQ-025 reg_addr SHALL equal the latched addr and stay constant while a strobe is high; reg_we and reg_re SHALL never be high together.
REQ-026 Timeout: if a strobe has been high ACK_TIMEOUT cycles without reg_ack, drop the strobe and set err_timeout. A read timeout loads spi_tx_data = all-ones and goes to RHOLD; a write timeout increments addr and goes to WDATA.
REQ-027 Overrun: spi_wr_req in WACC SHALL set err_overrun and drop the byte; the in-flight write continues.
REQ-028 Underrun: spi_rd_req in RACC SHALL set err_underrun; spi_tx_data keeps its old value, and the fetch completes and lands in RHOLD.
REQ-029 Error flags SHALL be sticky until the next transaction start or reset.
REQ-030 cs_active falling in any state: go to IDLE next cycle and drop strobes immediately, without incrementing addr. A reg_ack arriving after the abort is ignored.

Reset
REQ-031 On reset_n low, asynchronously: state = IDLE; spi_tx_data, reg_addr, reg_wdata = 0; reg_we, reg_re, busy and all error flags = 0; synchronizer = inactive.
REQ-032 Reset mid-access SHALL abort without a completing strobe, and the block SHALL resume only at the next cs_active rising edge.

Verification
REQ-033 Write burst: CS low, bytes 0x05, 0xAA, 0xBB with reg_ack after 2 cycles -> writes 0xAA@5 and 0xBB@6, no errors.
REQ-034 Read burst with wrap: command 0xFF, rdata = addr+0x10, two rd_req -> spi_tx_data 0x8F, then 0x10 (addr 0); reg_re at 0x7F, 0x00, 0x01.
REQ-035 Timeout: command 0x83, reg_ack never given -> reg_re held 15 cycles, err_timeout=1, spi_tx_data=0xFF.
REQ-036 Overrun/underrun: spi_wr_req during WACC -> err_overrun=1 and the byte is not written; spi_rd_req during RACC -> err_underrun=1; both clear at the next CS assertion.
REQ-037 Abort: CS deasserted while reg_we is pending -> reg_we=0 within 3 cycles of the raw CS edge, busy=0, and a late reg_ack causes no change.
REQ-038 Reset asserted in RHOLD -> all outputs 0 immediately, and no access occurs until CS is re-asserted.
